l2_flush_walker: RTL and testbench



---
 rtl/l2_flush_walker.sv | 167 ++++++++++++++++
 tb/tb_l2_flush_walker.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_flush_walker.sv
// L2 flush sequencer: walks every (set, way), writes back dirty lines,
// optionally invalidates valid ones, then drains outstanding MSHRs.
module l2_flush_walker #(
  parameter int SET_BITS     = 8,
  parameter int WAY_BITS     = 3,
  parameter int N_MSHR       = 4,
  parameter int MSHR_BITS_P1 = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_req_valid,
  output logic                    flush_req_ready,
  input  logic                    flush_wb_only,
  output logic                    flush_done,
  input  logic                    ongoing_flush,
  input  logic [SET_BITS:0]       flush_set,
  input  logic [WAY_BITS:0]       flush_way,
  input  logic [MSHR_BITS_P1-1:0] mshr_cnt,
  output logic                    set_ongoing_flush,
  output logic                    clr_ongoing_flush,
  output logic                    clr_flush_set,
  output logic                    incr_flush_set,
  output logic                    clr_flush_way,
  output logic                    incr_flush_way,
  output logic                    add_mshr_entry,
  output logic                    rd_en,
  input  logic                    rd_gnt,
  output logic [SET_BITS-1:0]     rd_set,
  output logic [WAY_BITS-1:0]     rd_way,
  input  logic                    line_valid,
  input  logic                    line_dirty,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [SET_BITS-1:0]     wb_set,
  output logic [WAY_BITS-1:0]     wb_way,
  output logic                    inv_en,
  output logic [SET_BITS-1:0]     inv_set,
  output logic [WAY_BITS-1:0]     inv_way
);

  typedef enum logic [2:0] {
    IDLE, READ, CHECK, WB, NEXT, DRAIN
  } state_t;

  state_t state_q, state_d;
  logic   wb_only_q, wb_only_d;

  logic way_last;
  logic set_last;
  logic mshr_avail;
  logic mshr_full;
  logic wb_hs;
  logic unused_bits;

  assign way_last   = &flush_way[WAY_BITS-1:0];
  assign set_last   = &flush_set[SET_BITS-1:0];
  assign mshr_avail = mshr_cnt != '0;
  assign mshr_full  = mshr_cnt == MSHR_BITS_P1'(N_MSHR);
  assign wb_hs      = (state_q == WB) && mshr_avail && wb_ready;

  assign rd_set  = flush_set[SET_BITS-1:0];
  assign rd_way  = flush_way[WAY_BITS-1:0];
  assign wb_set  = flush_set[SET_BITS-1:0];
  assign wb_way  = flush_way[WAY_BITS-1:0];
  assign inv_set = flush_set[SET_BITS-1:0];
  assign inv_way = flush_way[WAY_BITS-1:0];

  // Counter overflow bits and the ongoing flag are owned by l2_regs.
  assign unused_bits = ^{flush_set[SET_BITS],
                         flush_way[WAY_BITS],
                         ongoing_flush};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wb_only_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_only_q <= wb_only_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wb_only_d = wb_only_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req_valid) begin
          state_d   = READ;
          wb_only_d = flush_wb_only;
        end
      end
      READ: begin
        if (rd_gnt) state_d = CHECK;
      end
      CHECK: begin
        state_d = line_dirty ? WB : NEXT;
      end
      WB: begin
        if (wb_hs) state_d = NEXT;
      end
      NEXT: begin
        state_d = (way_last && set_last) ? DRAIN : READ;
      end
      DRAIN: begin
        if (mshr_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_req_ready   = 1'b0;
    flush_done        = 1'b0;
    set_ongoing_flush = 1'b0;
    clr_ongoing_flush = 1'b0;
    clr_flush_set     = 1'b0;
    incr_flush_set    = 1'b0;
    clr_flush_way     = 1'b0;
    incr_flush_way    = 1'b0;
    add_mshr_entry    = 1'b0;
    rd_en             = 1'b0;
    wb_valid          = 1'b0;
    inv_en            = 1'b0;
    unique case (state_q)
      IDLE: begin
        flush_req_ready = 1'b1;
        if (flush_req_valid) begin
          set_ongoing_flush = 1'b1;
          clr_flush_set     = 1'b1;
          clr_flush_way     = 1'b1;
        end
      end
      READ: begin
        rd_en = 1'b1;
      end
      CHECK: begin
        inv_en = !line_dirty && line_valid && !wb_only_q;
      end
      WB: begin
        wb_valid = mshr_avail;
        if (wb_hs) begin
          add_mshr_entry = 1'b1;
          inv_en         = !wb_only_q;
        end
      end
      NEXT: begin
        if (way_last) begin
          clr_flush_way  = 1'b1;
          incr_flush_set = 1'b1;
        end else begin
          incr_flush_way = 1'b1;
        end
      end
      DRAIN: begin
        if (mshr_full) begin
          clr_ongoing_flush = 1'b1;
          flush_done        = 1'b1;
          clr_flush_set     = 1'b1;
          clr_flush_way     = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2_flush_walker.sv
// Randomised bench for l2_flush_walker with an l2_regs model and a
// transaction-level expectation of the walk (reads, writebacks, invalidates).
module tb_l2_flush_walker;

  localparam int NL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_req_valid, flush_req_ready, flush_wb_only, flush_done;
  logic       ongoing;
  logic [2:0] fs;
  logic [1:0] fw;
  logic [1:0] mshr_q;
  logic       set_ong, clr_ong, clr_fs, incr_fs, clr_fw, incr_fw, add_m;
  logic       rd_en, rd_gnt, line_valid, line_dirty;
  logic [1:0] rd_set, wb_set, inv_set;
  logic [0:0] rd_way, wb_way, inv_way;
  logic       wb_valid, wb_ready, inv_en;

  l2_flush_walker #(
    .SET_BITS(2), .WAY_BITS(1), .N_MSHR(2), .MSHR_BITS_P1(2)
  ) dut (
    .clk(clk), .rst(rst),
    .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready),
    .flush_wb_only(flush_wb_only), .flush_done(flush_done),
    .ongoing_flush(ongoing), .flush_set(fs), .flush_way(fw),
    .mshr_cnt(mshr_q),
    .set_ongoing_flush(set_ong), .clr_ongoing_flush(clr_ong),
    .clr_flush_set(clr_fs), .incr_flush_set(incr_fs),
    .clr_flush_way(clr_fw), .incr_flush_way(incr_fw),
    .add_mshr_entry(add_m),
    .rd_en(rd_en), .rd_gnt(rd_gnt), .rd_set(rd_set), .rd_way(rd_way),
    .line_valid(line_valid), .line_dirty(line_dirty),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_set(wb_set), .wb_way(wb_way),
    .inv_en(inv_en), .inv_set(inv_set), .inv_way(inv_way)
  );

  always #5 clk = ~clk;

  int  n_chk = 0, n_fail = 0;
  int  cyc = 0;
  bit  lv_a [NL];
  bit  ld_a [NL];

  // stimulus knobs (written by main only)
  bit  req_pend = 0, req_wbo = 0;
  bit  gnt_rand = 0, rdy_rand = 0, rdy_block = 0;
  bit  ack_hold = 0, ack_fast = 0;
  int  stall_cfg = 0;
  int  stall_left = 0;
  logic ack_now;

  // model state (written by compare process only)
  bit  busy = 0, m_wbo = 0;
  int  exp_rd[$], exp_wb[$], exp_inv[$];
  int  nrd, nwb, ninv, ndone = 0;
  int  bld_wb, bld_inv;
  int  acc_cyc, done_cyc, last_wb;
  bit  prev_wbv = 0, prev_wbr = 0;
  int  prev_wa = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // l2_regs model
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fs <= '0; fw <= '0; ongoing <= 1'b0; mshr_q <= 2'd2;
    end else begin
      fs <= clr_fs ? 3'd0 : incr_fs ? fs + 3'd1 : fs;
      fw <= clr_fw ? 2'd0 : incr_fw ? fw + 2'd1 : fw;
      ongoing <= set_ong ? 1'b1 : clr_ong ? 1'b0 : ongoing;
      mshr_q <= mshr_q - 2'(add_m) + 2'(ack_now);
    end
  end

  // tag/state array: data one cycle after the grant, noise otherwise
  always @(posedge clk) begin
    if (rd_en && rd_gnt) begin
      line_valid <= lv_a[{rd_set, rd_way}];
      line_dirty <= ld_a[{rd_set, rd_way}];
    end else begin
      line_valid <= 1'($urandom);
      line_dirty <= 1'($urandom);
    end
  end

  // input driver, 1 time unit after the active edge
  initial begin
    flush_req_valid = 0; flush_wb_only = 0;
    rd_gnt = 0; wb_ready = 0; ack_now = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      flush_req_valid = busy ? 1'($urandom) : req_pend;
      flush_wb_only   = req_pend ? req_wbo : 1'($urandom);
      if (!busy) stall_left = stall_cfg;
      if (busy && rd_en && stall_left > 0) begin
        rd_gnt = 0;
        stall_left--;
      end else begin
        rd_gnt = gnt_rand ? 1'($urandom) : 1'b1;
      end
      wb_ready = rdy_block ? 1'b0 : rdy_rand ? 1'($urandom) : 1'b1;
      ack_now  = !ack_hold && mshr_q < 2'd2 &&
                 (ack_fast || ($urandom % 4 == 0));
    end
  end

  // compare process
  always @(negedge clk) begin
    if (!rst) begin
      busy = 0; prev_wbv = 0;
      exp_rd.delete(); exp_wb.delete(); exp_inv.delete();
    end else begin
      chk("idx", {rd_set, rd_way, wb_set, wb_way, inv_set, inv_way},
          {fs[1:0], fw[0], fs[1:0], fw[0], fs[1:0], fw[0]});
      chk("ready", flush_req_ready, !busy);
      if (!busy)
        chk("idle_quiet", {rd_en, wb_valid, inv_en, add_m, incr_fs,
                           incr_fw, flush_done, clr_ong}, 0);
      chk("set_ongoing", set_ong, !busy && flush_req_valid);
      chk("ctr_excl", (clr_fs && incr_fs) || (clr_fw && incr_fw), 0);
      chk("add_mshr", add_m, wb_valid && wb_ready);
      if (wb_valid) chk("wb_mshr_avail", mshr_q != 0, 1);
      if (prev_wbv && !prev_wbr && mshr_q != 0)
        chk("wb_hold", {wb_valid, wb_set, wb_way}, {1'b1, 3'(prev_wa)});
      if (rd_en && rd_gnt) begin
        if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_addr", {rd_set, rd_way}, exp_rd.pop_front());
        nrd++;
      end
      if (wb_valid && wb_ready) begin
        if (exp_wb.size() == 0) chk("wb_extra", 1, 0);
        else chk("wb_addr", {wb_set, wb_way}, exp_wb.pop_front());
        chk("wb_inv", inv_en, !m_wbo);
        last_wb = {wb_set, wb_way};
        nwb++;
      end
      if (inv_en) begin
        if (exp_inv.size() == 0) chk("inv_extra", 1, 0);
        else chk("inv_addr", {inv_set, inv_way}, exp_inv.pop_front());
        ninv++;
      end
      if (flush_done) begin
        chk("done_left", exp_rd.size() + exp_wb.size() + exp_inv.size(), 0);
        chk("done_mshr", mshr_q, 2);
        chk("done_clr", {clr_ong, clr_fs, clr_fw, ongoing}, 4'b1111);
        busy = 0;
        done_cyc = cyc;
        ndone++;
      end
      if (flush_req_ready && flush_req_valid) begin
        m_wbo = flush_wb_only;
        for (int i = 0; i < NL; i++) begin
          exp_rd.push_back(i);
          if (ld_a[i]) exp_wb.push_back(i);
          if ((ld_a[i] || lv_a[i]) && !m_wbo) exp_inv.push_back(i);
        end
        bld_wb = exp_wb.size(); bld_inv = exp_inv.size();
        nrd = 0; nwb = 0; ninv = 0;
        acc_cyc = cyc;
        busy = 1;
      end
      prev_wbv = wb_valid; prev_wbr = wb_ready;
      prev_wa  = {wb_set, wb_way};
    end
  end

  task automatic set_lines(input logic [7:0] v, input logic [7:0] d);
    for (int i = 0; i < NL; i++) begin
      lv_a[i] = v[i]; ld_a[i] = d[i];
    end
  endtask

  task automatic start_flush(input bit w);
    req_wbo = w; req_pend = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (busy) break;
    end
    req_pend = 0;
    chk("accepted", busy, 1);
  endtask

  task automatic wait_done(input int n0, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (ndone != n0) break;
      @(negedge clk); #1;
    end
    chk("done_timeout", ndone != n0, 1);
  endtask

  task automatic run_flush(input bit w, input int budget);
    int n0;
    n0 = ndone;
    start_flush(w);
    wait_done(n0, budget);
  endtask

  initial begin
    rst = 0;
    set_lines(8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", flush_req_ready, 1);
    chk("rst_outs", {rd_en, wb_valid, inv_en, flush_done, add_m, set_ong,
                     clr_ong, clr_fs, incr_fs, clr_fw, incr_fw}, 0);
    chk("rst_idx", {rd_set, rd_way, wb_set, wb_way, inv_set, inv_way}, 0);
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);

    // clean walk, immediate grant: 26 cycles including the accept cycle
    run_flush(0, 200);
    chk("t1_latency", done_cyc - acc_cyc, 25);
    chk("t1_reads", nrd, 8);
    chk("t1_wb_inv", nwb + ninv, 0);

    // single dirty line (2,1) with invalidate
    set_lines(8'h20, 8'h20);
    run_flush(0, 300);
    chk("t2_model_wb", bld_wb, 1);
    chk("t2_model_inv", bld_inv, 1);
    chk("t2_wb_cnt", nwb, 1);
    chk("t2_wb_addr", last_wb, 5);
    chk("t2_inv_cnt", ninv, 1);

    // writeback-only, all valid, (0,0) and (3,1) dirty
    set_lines(8'hFF, 8'h81);
    run_flush(1, 300);
    chk("t3_wb_cnt", nwb, 2);
    chk("t3_inv_cnt", ninv, 0);

    // MSHRs exhausted at (1,0)
    set_lines(8'h07, 8'h07);
    ack_hold = 1;
    begin
      int n0;
      n0 = ndone;
      start_flush(0);
      for (int i = 0; i < 100; i++) begin
        if (exp_rd.size() <= 5) break;
        @(negedge clk); #1;
      end
      repeat (4) @(negedge clk);
      #1;
      chk("t4_mshr_zero", mshr_q, 0);
      chk("t4_hold", {wb_valid, rd_en, wb_set, wb_way}, {2'b00, 3'd2});
      ack_hold = 0; ack_fast = 1;
      for (int i = 0; i < 10; i++) begin
        if (mshr_q != 0) break;
        @(negedge clk); #1;
      end
      chk("t4_wb_rise", wb_valid, 1);
      wait_done(n0, 300);
      ack_fast = 0;
      chk("t4_wb_cnt", nwb, 3);
    end

    // five-cycle grant stall on the first read
    set_lines(8'h00, 8'h00);
    stall_cfg = 5;
    run_flush(0, 200);
    stall_cfg = 0;
    chk("t5_latency", done_cyc - acc_cyc, 30);

    // randomised walks
    gnt_rand = 1; rdy_rand = 1;
    for (int k = 0; k < 6; k++) begin
      set_lines(8'($urandom), 8'($urandom) & 8'($urandom));
      run_flush(1'($urandom), 1500);
    end
    gnt_rand = 0; rdy_rand = 0;

    // reset while stalled in WB at (1,1)
    set_lines(8'h08, 8'h08);
    rdy_block = 1;
    start_flush(0);
    for (int i = 0; i < 100; i++) begin
      if (wb_valid && wb_set == 2'd1 && wb_way == 1'b1) break;
      @(negedge clk); #1;
    end
    chk("t7_in_wb", {wb_valid, wb_set, wb_way}, 4'b1011);
    @(posedge clk); #2;
    rst = 0;
    #1;
    chk("t7_rst_ready", flush_req_ready, 1);
    chk("t7_rst_outs", {rd_en, wb_valid, inv_en, flush_done, add_m,
                        clr_ong, incr_fs, incr_fw}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1;
    rdy_block = 0;
    @(negedge clk);
    run_flush(0, 300);
    chk("t7_reads", nrd, 8);
    chk("t7_wb_addr", last_wb, 3);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
